// File: rtl/if_fetch_unit.sv
// -----------------------------------------------------------------------------
// if_fetch_unit
//
// Instruction-fetch (IF) stage. It owns the PC and drives a synchronous
// instruction memory that has a one-cycle read latency. It follows the hold,
// nop and jump controls from the hazard-control unit and presents
// pc/instruction/valid to the ID stage.
//
// Handshake semantics:
//   - The memory side uses an enable/data pair. When imem_en=1 in cycle N,
//     imem_rdata carries mem[imem_addr] in cycle N+1. When imem_en=0, the
//     memory keeps its previous rdata.
//   - The ID side has no back-pressure. IF_inst_vld=1 marks IF_pc/IF_inst as a
//     real, non-squashed instruction in that cycle. When IF_inst_vld=0,
//     IF_inst carries NOP_INST.
//   - Stalls are applied through hold_IF. While the stage is held, the word
//     on the ID side is presented again unchanged.
//
// Ports:
//   clk          : clock; all state updates happen on the rising edge
//   rst_n        : synchronous active-low reset
//   hold_IF      : freeze the PC and the memory read (load-use stall)
//   nop_IF       : force a bubble on the ID-facing output this cycle
//   jmp_vld_IF   : redirect request
//   jmp_addr_IF  : redirect target (bits [1:0] are dropped)
//   imem_en      : memory read enable
//   imem_addr    : memory read address (the PC register)
//   imem_rdata   : memory read data; valid the cycle after imem_en=1
//   IF_pc        : PC of the word on IF_inst
//   IF_inst      : instruction to ID (NOP_INST when not valid)
//   IF_inst_vld  : IF_inst is a valid, non-squashed instruction
//   jmp_misalign : one-cycle pulse after an accepted jump whose target had
//                  bits [1:0] != 0
//   fetch_cnt    : count of cycles with IF_inst_vld=1 (wraps)
//   flush_cnt    : count of accepted redirects (wraps)
//   fsm_state    : debug view of the fetch FSM (0=IDLE, 1=FETCH, 2=FLUSH)
// -----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_IF,
  input  logic        nop_IF,
  input  logic        jmp_vld_IF,
  input  logic [31:0] jmp_addr_IF,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_pc,
  output logic [31:0] IF_inst,
  output logic        IF_inst_vld,
  output logic        jmp_misalign,
  output logic [31:0] fetch_cnt,
  output logic [31:0] flush_cnt,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] if_pc_q;
  logic        inst_ok_q;     // word now on imem_rdata was not fetched on a redirect cycle
  logic        misalign_q;
  logic [31:0] fetch_cnt_q;
  logic [31:0] flush_cnt_q;

  // A jump always fetches, even during a hold: the redirect takes priority
  // over the stall.
  assign imem_en   = (state_q != IDLE) & (~hold_IF | jmp_vld_IF);
  assign imem_addr = pc_q;

  // In FLUSH the data on imem_rdata belongs to the wrong path. The state
  // check squashes it. inst_ok_q squashes the word fetched in the same
  // cycle that a jump was accepted.
  assign IF_inst_vld = (state_q == FETCH) & inst_ok_q & ~nop_IF;
  assign IF_inst     = IF_inst_vld ? imem_rdata : NOP_INST;
  assign IF_pc       = if_pc_q;

  assign jmp_misalign = misalign_q;
  assign fetch_cnt    = fetch_cnt_q;
  assign flush_cnt    = flush_cnt_q;
  assign fsm_state    = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      if_pc_q     <= RESET_PC;
      inst_ok_q   <= 1'b0;
      misalign_q  <= 1'b0;
      fetch_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      // Next-state logic for the fetch FSM.
      case (state_q)
        IDLE:    state_q <= FETCH;
        FETCH:   if (jmp_vld_IF) state_q <= FLUSH;
        FLUSH:   if (!jmp_vld_IF && !hold_IF) state_q <= FETCH;
        default: state_q <= IDLE;
      endcase

      // Next-PC selection: jump, then hold, then sequential.
      // The +4 increment wraps naturally at 2^32.
      if (jmp_vld_IF) begin
        pc_q        <= {jmp_addr_IF[31:2], 2'b00};
        flush_cnt_q <= flush_cnt_q + 32'd1;
      end else if (!hold_IF && (state_q != IDLE)) begin
        pc_q <= pc_q + 32'd4;
      end

      // This register is rewritten every cycle, so the flag is high for
      // exactly one cycle after each misaligned jump.
      misalign_q <= jmp_vld_IF & (|jmp_addr_IF[1:0]);

      // These registers track the word in flight. They update only when a
      // read is issued, so they stay aligned with the frozen memory output
      // during a hold.
      if (imem_en) begin
        if_pc_q   <= pc_q;
        inst_ok_q <= ~jmp_vld_IF;
      end

      if (IF_inst_vld) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
    end
  end

endmodule
